// File: rtl/note_scheduler.sv
// note_scheduler: fetches a song note by note from ROM and times each note's silent gap, tone, and optional learn-mode wait for the player's key. Define NOTE_SCHED_LOOP_EN to make playback loop continuously.
module note_scheduler #(
  parameter int UNIT_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] song_sel,
  input  logic [6:0] song_len,
  input  logic       learn_mode,
  input  logic       key_match,
  output logic       rom_req,
  output logic [7:0] rom_addr,
  input  logic       rom_ack,
  input  logic [7:0] rom_data,
  output logic [5:0] note_code,
  output logic       tone_en,
  output logic [5:0] note_index,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, FETCH, GAP, PLAY, WAIT_KEY, DONE} state_t;
  state_t      state, state_n;
  logic [1:0]  song;
  logic [6:0]  len;
  logic [5:0]  idx;
  logic [5:0]  pitch;
  logic [1:0]  dcls;
  logic [31:0] cnt;
  logic [31:0] total;
  logic        run, last, wants_key, note_end, adv;
  assign total     = 32'(UNIT_CYCLES) << dcls;
  assign run       = !pause;
  assign last      = ({1'b0, idx} == len - 7'd1) || (idx == 6'd63);
  assign wants_key = learn_mode && (pitch != 6'd0);
  assign note_end  = (state == PLAY) && run && (cnt == total - 32'd1);
  assign adv       = !stop && ((note_end && !wants_key) || ((state == WAIT_KEY) && run && key_match));
  assign busy       = state != IDLE;
  assign rom_req    = (state == FETCH) && !stop;
  assign rom_addr   = {song, idx};
  assign note_code  = pitch;
  assign note_index = idx;
  assign tone_en    = (state == PLAY) && (pitch != 6'd0) && run && !stop;
`ifdef NOTE_SCHED_LOOP_EN
  assign done = !stop && ((state == DONE) || (adv && last));
`else
  assign done = !stop && (state == DONE);
`endif
  // next-state selection: per-state transitions, then note advance, then stop overrides all
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start) state_n = (song_len == 7'd0) ? DONE : FETCH;
      FETCH:    if (rom_ack) state_n = (GAP_CYCLES == 0) ? PLAY : GAP;
      GAP:      if (run && cnt == 32'(GAP_CYCLES) - 32'd1) state_n = PLAY;
      PLAY:     if (note_end && wants_key) state_n = WAIT_KEY;
      WAIT_KEY: state_n = WAIT_KEY;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
`ifdef NOTE_SCHED_LOOP_EN
    if (adv) state_n = FETCH;
`else
    if (adv) state_n = last ? DONE : FETCH;
`endif
    if (stop) state_n = IDLE;
  end
  // state, song latches, captured note and the pausable duration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      song  <= 2'd0;
      len   <= 7'd0;
      idx   <= 6'd0;
      pitch <= 6'd0;
      dcls  <= 2'd0;
      cnt   <= 32'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && start && !stop) begin
        song <= song_sel;
        len  <= song_len;
        idx  <= 6'd0;
      end
      if (state == FETCH && rom_ack && !stop) begin
        pitch <= rom_data[5:0];
        dcls  <= rom_data[7:6];
        cnt   <= 32'd0;
      end
      if ((state == GAP || state == PLAY) && run && !stop) cnt <= cnt + 32'd1;
`ifdef NOTE_SCHED_LOOP_EN
      if (adv) idx <= last ? 6'd0 : idx + 6'd1;
`else
      if (adv && !last) idx <= idx + 6'd1;
`endif
    end
  end
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: builds a per-cycle expected timeline for each song from the note rules, then replays stimulus and compares every cycle.
module tb_note_scheduler;
  localparam int UNIT = 10;
  localparam int GAP  = 2;
  localparam int MAXC = 256;
  logic clk = 0, rst = 1, start = 0, stop = 0, pause = 0, learn_mode = 0, key_match = 0;
  logic [1:0] song_sel = 0;
  logic [6:0] song_len = 0;
  logic rom_ack;
  logic [7:0] rom_data;
  logic rom_req, tone_en, busy, done;
  logic [7:0] rom_addr;
  logic [5:0] note_code, note_index;
  note_scheduler #(.UNIT_CYCLES(UNIT), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .song_sel(song_sel),
    .song_len(song_len), .learn_mode(learn_mode), .key_match(key_match), .rom_req(rom_req),
    .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data), .note_code(note_code),
    .tone_en(tone_en), .note_index(note_index), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  logic [7:0] rom [256];
  logic ack_en = 1;
  // ROM answers one cycle after a request
  always @(posedge clk) begin
    if (rst) rom_ack <= 1'b0;
    else begin
      rom_ack  <= rom_req && !rom_ack && ack_en;
      rom_data <= rom[rom_addr];
    end
  end
  typedef struct {
    logic req; logic [7:0] addr; logic tone; logic [5:0] code;
    logic busy; logic done; logic [5:0] idx; logic care;
  } exp_t;
  exp_t ex [MAXC];
  logic s_start [MAXC], s_stop [MAXC], s_pause [MAXC], s_key [MAXC], s_rst [MAXC], s_ackoff [MAXC];
  int n = 0, cyc = 0, checks = 0, errors = 0, tone_cnt = 0, done_cnt = 0;
  int m_song = 0, m_idx = 0;
  logic [5:0] m_pitch = 0;
  logic active = 0;
  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask
  task automatic clear();
    n = 0;
    for (int i = 0; i < MAXC; i++) begin
      s_start[i] = 0; s_stop[i] = 0; s_pause[i] = 0; s_key[i] = 0; s_rst[i] = 0; s_ackoff[i] = 0;
    end
  endtask
  task automatic push(input logic req, input logic tone, input logic bsy, input logic dn, input logic care);
    ex[n].req  = req;
    ex[n].addr = {m_song[1:0], m_idx[5:0]};
    ex[n].tone = tone;
    ex[n].code = m_pitch;
    ex[n].busy = bsy;
    ex[n].done = dn;
    ex[n].idx  = m_idx[5:0];
    ex[n].care = care;
    n++;
  endtask
  task automatic push_idle(input int k);
    for (int i = 0; i < k; i++) push(0, 0, 0, 0, 1);
  endtask
  // one note: two fetch cycles, then units*UNIT cycles of gap+tone, frozen wherever pause is high
  task automatic gen_note(input int s, input int i);
    logic [7:0] d;
    int tot, t;
    m_idx = i;
    push(1, 0, 1, 0, 1);
    push(1, 0, 1, 0, 1);
    d = rom[8'(s * 64 + i)];
    m_pitch = d[5:0];
    tot = UNIT << d[7:6];
    t = 0;
    while (t < tot) begin
      if (s_pause[n]) push(0, 0, 1, 0, 1);
      else begin
        push(0, (t >= GAP) && (m_pitch != 0), 1, 0, 1);
        t++;
      end
    end
  endtask
  task automatic build_play(input int s, input int len, input bit learn, input int wait_k);
    s_start[n] = 1;
    push(0, 0, 0, 0, 1);
    m_song = s;
    m_idx = 0;
    for (int i = 0; i < len; i++) begin
      gen_note(s, i);
      if (learn && m_pitch != 0) begin
        for (int k = 0; k < wait_k; k++) push(0, 0, 1, 0, 1);
        while (s_pause[n]) push(0, 0, 1, 0, 1);
        s_key[n] = 1;
        push(0, 0, 1, 0, 1);
      end
    end
    push(0, 0, 1, 1, 1);
    push_idle(3);
  endtask
  task automatic run();
    tone_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      start = s_start[c]; stop = s_stop[c]; pause = s_pause[c];
      key_match = s_key[c]; rst = s_rst[c]; ack_en = !s_ackoff[c];
      cyc = c;
      active = 1;
    end
    @(posedge clk);
    #1;
    active = 0;
    start = 0; stop = 0; pause = 0; key_match = 0; rst = 0; ack_en = 1;
  endtask
  // compare DUT outputs with the expected timeline on every cycle of a scenario
  always @(negedge clk) begin
    if (active && ex[cyc].care) begin
      chk($sformatf("rom_req@%0d", cyc), int'(rom_req), int'(ex[cyc].req));
      chk($sformatf("rom_addr@%0d", cyc), int'(rom_addr), int'(ex[cyc].addr));
      chk($sformatf("tone_en@%0d", cyc), int'(tone_en), int'(ex[cyc].tone));
      chk($sformatf("busy@%0d", cyc), int'(busy), int'(ex[cyc].busy));
      chk($sformatf("done@%0d", cyc), int'(done), int'(ex[cyc].done));
      chk($sformatf("note_index@%0d", cyc), int'(note_index), int'(ex[cyc].idx));
      if (ex[cyc].tone) chk($sformatf("note_code@%0d", cyc), int'(note_code), int'(ex[cyc].code));
      tone_cnt += int'(tone_en);
      done_cnt += int'(done);
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h40] = 8'h41; rom[8'h41] = 8'h05;
    rom[8'h80] = 8'h80;
    rom[8'hC0] = 8'h03; rom[8'hC1] = 8'h00;
    rom[8'h00] = 8'h43; rom[8'h01] = 8'h02;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_req", int'(rom_req), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_note_code", int'(note_code), 0);
    chk("rst_tone_en", int'(tone_en), 0);
    chk("rst_note_index", int'(note_index), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 0;
`ifdef NOTE_SCHED_LOOP_EN
    clear();
    song_sel = 0; song_len = 1; learn_mode = 0;
    s_start[0] = 1;
    push(0, 0, 0, 0, 1);
    m_song = 0;
    for (int r = 0; r < 3; r++) begin
      gen_note(0, 0);
      ex[n-1].done = 1;
    end
    s_stop[n] = 1;
    push(0, 0, 0, 0, 0);
    push_idle(3);
    chk("loop_len", n, 71);
    run();
    chk("loop_tone_cnt", tone_cnt, 54);
    chk("loop_done_cnt", done_cnt, 3);
`else
    clear();
    song_sel = 1; song_len = 2; learn_mode = 0;
    s_start[12] = 1;
    build_play(1, 2, 0, 0);
    chk("t1_len", n, 39);
    run();
    chk("t1_tone_cnt", tone_cnt, 26);
    chk("t1_done_cnt", done_cnt, 1);
    clear();
    song_sel = 2; song_len = 1; learn_mode = 1;
    build_play(2, 1, 1, 0);
    chk("t2_len", n, 47);
    run();
    chk("t2_tone_cnt", tone_cnt, 0);
    chk("t2_done_cnt", done_cnt, 1);
    clear();
    song_sel = 3; song_len = 2; learn_mode = 1;
    s_key[5] = 1;
    build_play(3, 2, 1, 50);
    chk("t3_len", n, 80);
    run();
    chk("t3_tone_cnt", tone_cnt, 8);
    clear();
    song_sel = 0; song_len = 1; learn_mode = 0;
    s_pause[1] = 1; s_pause[2] = 1;
    for (int c = 10; c < 17; c++) s_pause[c] = 1;
    build_play(0, 1, 0, 0);
    chk("t4_len", n, 34);
    run();
    chk("t4_tone_cnt", tone_cnt, 18);
    clear();
    song_sel = 1; song_len = 3; learn_mode = 0;
    for (int c = 0; c < 8; c++) s_ackoff[c] = 1;
    s_start[0] = 1;
    push(0, 0, 0, 0, 1);
    m_song = 1; m_idx = 0;
    repeat (3) push(1, 0, 1, 0, 1);
    s_stop[4] = 1; s_start[4] = 1;
    push(0, 0, 0, 0, 0);
    s_stop[5] = 1; s_start[5] = 1;
    push_idle(4);
    run();
    chk("t5_done_cnt", done_cnt, 0);
    clear();
    song_sel = 1; song_len = 0;
    build_play(1, 0, 0, 0);
    chk("t6_len", n, 5);
    run();
    chk("t6_done_cnt", done_cnt, 1);
    clear();
    song_sel = 0; song_len = 2;
    s_start[0] = 1;
    push(0, 0, 0, 0, 1);
    m_song = 0; m_idx = 0;
    push(1, 0, 1, 0, 1);
    push(1, 0, 1, 0, 1);
    m_pitch = 6'd3;
    push(0, 0, 1, 0, 1);
    push(0, 0, 1, 0, 1);
    repeat (3) push(0, 1, 1, 0, 1);
    s_rst[n] = 1;
    push(0, 0, 0, 0, 0);
    m_song = 0; m_idx = 0;
    push_idle(3);
    run();
    chk("t7_tone_cnt", tone_cnt, 3);
    chk("t7_done_cnt", done_cnt, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
